// File: rtl/ysyx_210544_cmt_sched_if.sv
// Commit scheduler bus: two commit sources in, one commit stream out.
// Master is the surrounding pipeline side, slave is the scheduler.
interface ysyx_210544_cmt_sched_if;
  logic         i_wb_req;
  logic         o_wb_ack;
  logic [203:0] i_wb_rec;
  logic         i_trp_req;
  logic         o_trp_ack;
  logic [203:0] i_trp_rec;
  logic         o_cmt_req;
  logic         i_cmt_ack;
  logic [203:0] o_cmt_rec;
  logic [63:0]  o_retire_cnt;
  logic         o_hang;
  logic         o_full;
  logic         o_empty;

  modport master (
    output i_wb_req, i_wb_rec,
    output i_trp_req, i_trp_rec,
    output i_cmt_ack,
    input  o_wb_ack, o_trp_ack,
    input  o_cmt_req, o_cmt_rec,
    input  o_retire_cnt, o_hang,
    input  o_full, o_empty
  );

  modport slave (
    input  i_wb_req, i_wb_rec,
    input  i_trp_req, i_trp_rec,
    input  i_cmt_ack,
    output o_wb_ack, o_trp_ack,
    output o_cmt_req, o_cmt_rec,
    output o_retire_cnt, o_hang,
    output o_full, o_empty
  );
endinterface

// File: rtl/ysyx_210544_cmt_sched.sv
// Commit scheduler: trap-priority arbiter, record FIFO,
// retire counter and commit-hang watchdog.
module ysyx_210544_cmt_sched #(
  parameter int DEPTH       = 4,
  parameter int HANG_CYCLES = 4096
) (
  input logic clk,
  input logic rst,
  ysyx_210544_cmt_sched_if.slave bus
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int WW    = $clog2(HANG_CYCLES + 1);
  localparam int NOCMT = 33;

  logic [203:0]  mem_q [DEPTH];
  logic [203:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   retire_q, retire_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          hang_q, hang_d;

  logic         full, empty, pop, push;
  logic         full_eff, trp_ack, wb_ack;
  logic [203:0] rec;
  logic [203:0] head;

  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    head     = mem_q[rd_ptr_q];
    pop      = !empty & bus.i_cmt_ack;
    // a pop in this cycle frees the slot the push needs
    full_eff = full & !pop;
    trp_ack  = bus.i_trp_req & !full_eff;
    wb_ack   = bus.i_wb_req & !bus.i_trp_req & !full_eff;
    push     = trp_ack | wb_ack;
    rec      = bus.i_trp_req ? bus.i_trp_rec : bus.i_wb_rec;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = rec;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    retire_d = retire_q;
    if (pop && !head[NOCMT]) retire_d = retire_q + 64'd1;

    wd_d = wd_q;
    if (pop || empty)
      wd_d = '0;
    else if (wd_q != WW'(HANG_CYCLES))
      wd_d = wd_q + 1'b1;

    hang_d = hang_q | (wd_d == WW'(HANG_CYCLES));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      retire_q <= '0;
      wd_q     <= '0;
      hang_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      retire_q <= retire_d;
      wd_q     <= wd_d;
      hang_q   <= hang_d;
    end
  end

  assign bus.o_trp_ack    = trp_ack;
  assign bus.o_wb_ack     = wb_ack;
  assign bus.o_cmt_req    = !empty;
  assign bus.o_cmt_rec    = empty ? '0 : head;
  assign bus.o_retire_cnt = retire_q;
  assign bus.o_hang       = hang_q;
  assign bus.o_full       = full;
  assign bus.o_empty      = empty;
endmodule

// File: tb/tb_ysyx_210544_cmt_sched.sv
// Directed bench for the commit scheduler.
// Inputs change 1ns after posedge; outputs sampled before next edge.
module tb_ysyx_210544_cmt_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ysyx_210544_cmt_sched_if bus ();

  ysyx_210544_cmt_sched #(
    .DEPTH(4),
    .HANG_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [203:0] mkrec(
    input logic [63:0] pc,
    input logic        nocmt,
    input logic        skip,
    input logic [31:0] intr
  );
    return {4'b0, 5'd1, 1'b1, 64'hdead, pc,
            32'h13, nocmt, skip, intr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_wb_req  = 1'b0;
    bus.i_wb_rec  = '0;
    bus.i_trp_req = 1'b0;
    bus.i_trp_rec = '0;
    bus.i_cmt_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #3;
    checks++;
    if (bus.o_empty !== 1'b1 || bus.o_cmt_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_empty got=%b/%b exp=1/0",
               bus.o_empty, bus.o_cmt_req);
    end
    checks++;
    if (bus.o_full !== 1'b0 || bus.o_hang !== 1'b0) begin
      failures++;
      $display("FAIL rst_full_hang got=%b/%b exp=0/0",
               bus.o_full, bus.o_hang);
    end
    checks++;
    if (bus.o_retire_cnt !== 64'd0 || bus.o_cmt_rec !== '0) begin
      failures++;
      $display("FAIL rst_cnt_rec got=%0h/%0h exp=0/0",
               bus.o_retire_cnt, bus.o_cmt_rec);
    end
    checks++;
    if (bus.o_wb_ack !== 1'b0 || bus.o_trp_ack !== 1'b0) begin
      failures++;
      $display("FAIL rst_acks got=%b/%b exp=0/0",
               bus.o_wb_ack, bus.o_trp_ack);
    end
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_single_wb();
    do_reset();
    tick();
    bus.i_wb_req  = 1'b1;
    bus.i_wb_rec  = mkrec(64'h8000_0000, 1'b0, 1'b0, 32'd0);
    bus.i_cmt_ack = 1'b1;
    #1;
    checks++;
    if (bus.o_wb_ack !== 1'b1 || bus.o_cmt_req !== 1'b0) begin
      failures++;
      $display("FAIL single_c0 got=%b/%b exp=1/0",
               bus.o_wb_ack, bus.o_cmt_req);
    end
    tick();
    bus.i_wb_req = 1'b0;
    #1;
    checks++;
    if (bus.o_cmt_req !== 1'b1 ||
        bus.o_cmt_rec[129:66] !== 64'h8000_0000 ||
        bus.o_retire_cnt !== 64'd0) begin
      failures++;
      $display("FAIL single_c1 got=%b/%0h/%0d exp=1/80000000/0",
               bus.o_cmt_req, bus.o_cmt_rec[129:66],
               bus.o_retire_cnt);
    end
    tick();
    checks++;
    if (bus.o_retire_cnt !== 64'd1 || bus.o_empty !== 1'b1) begin
      failures++;
      $display("FAIL single_c2 got=%0d/%b exp=1/1",
               bus.o_retire_cnt, bus.o_empty);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    bus.i_wb_req  = 1'b1;
    bus.i_wb_rec  = mkrec(64'h100, 1'b0, 1'b0, 32'd0);
    bus.i_trp_req = 1'b1;
    bus.i_trp_rec = mkrec(64'h200, 1'b0, 1'b0, 32'd7);
    #1;
    checks++;
    if (bus.o_trp_ack !== 1'b1 || bus.o_wb_ack !== 1'b0) begin
      failures++;
      $display("FAIL arb_prio got=trp%b/wb%b exp=1/0",
               bus.o_trp_ack, bus.o_wb_ack);
    end
    tick();
    bus.i_trp_req = 1'b0;
    #1;
    checks++;
    if (bus.o_wb_ack !== 1'b1 || bus.o_cmt_rec[31:0] !== 32'd7) begin
      failures++;
      $display("FAIL arb_wb_next got=%b/%0d exp=1/7",
               bus.o_wb_ack, bus.o_cmt_rec[31:0]);
    end
    tick();
    bus.i_wb_req  = 1'b0;
    bus.i_cmt_ack = 1'b1;
    #1;
    checks++;
    if (bus.o_cmt_rec[129:66] !== 64'h200) begin
      failures++;
      $display("FAIL arb_first got=%0h exp=200",
               bus.o_cmt_rec[129:66]);
    end
    tick();
    checks++;
    if (bus.o_cmt_rec[129:66] !== 64'h100 ||
        bus.o_cmt_rec[31:0] !== 32'd0) begin
      failures++;
      $display("FAIL arb_second got=%0h/%0d exp=100/0",
               bus.o_cmt_rec[129:66], bus.o_cmt_rec[31:0]);
    end
    tick();
    checks++;
    if (bus.o_empty !== 1'b1 || bus.o_retire_cnt !== 64'd2) begin
      failures++;
      $display("FAIL arb_drain got=%b/%0d exp=1/2",
               bus.o_empty, bus.o_retire_cnt);
    end
  endtask

  task automatic test_full_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.i_wb_req = 1'b1;
      bus.i_wb_rec = mkrec(64'(i * 4), 1'b0, 1'b0, 32'd0);
      #1;
      checks++;
      if (bus.o_wb_ack !== 1'b1) begin
        failures++;
        $display("FAIL full_push%0d got=%b exp=1", i, bus.o_wb_ack);
      end
      tick();
    end
    bus.i_wb_rec = mkrec(64'd16, 1'b0, 1'b0, 32'd0);
    #1;
    checks++;
    if (bus.o_full !== 1'b1 || bus.o_wb_ack !== 1'b0) begin
      failures++;
      $display("FAIL full_block got=%b/%b exp=1/0",
               bus.o_full, bus.o_wb_ack);
    end
    tick();
    checks++;
    if (bus.o_wb_ack !== 1'b0 || bus.o_cmt_rec[129:66] !== 64'd0) begin
      failures++;
      $display("FAIL full_hold got=%b/%0h exp=0/0",
               bus.o_wb_ack, bus.o_cmt_rec[129:66]);
    end
    bus.i_cmt_ack = 1'b1;
    #1;
    checks++;
    if (bus.o_wb_ack !== 1'b1) begin
      failures++;
      $display("FAIL full_pushpop got=%b exp=1", bus.o_wb_ack);
    end
    tick();
    bus.i_wb_req  = 1'b0;
    bus.i_cmt_ack = 1'b0;
    #1;
    checks++;
    if (bus.o_full !== 1'b1 || bus.o_cmt_rec[129:66] !== 64'd4) begin
      failures++;
      $display("FAIL full_after got=%b/%0h exp=1/4",
               bus.o_full, bus.o_cmt_rec[129:66]);
    end
    bus.i_cmt_ack = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      checks++;
      if (bus.o_cmt_rec[129:66] !== 64'(i * 4)) begin
        failures++;
        $display("FAIL full_order%0d got=%0h exp=%0h",
                 i, bus.o_cmt_rec[129:66], i * 4);
      end
      tick();
    end
    checks++;
    if (bus.o_empty !== 1'b1 || bus.o_retire_cnt !== 64'd5) begin
      failures++;
      $display("FAIL full_drain got=%b/%0d exp=1/5",
               bus.o_empty, bus.o_retire_cnt);
    end
    bus.i_cmt_ack = 1'b0;
  endtask

  task automatic test_nocmt();
    logic [2:0] nc;
    logic [2:0] sk;
    nc = 3'b001;
    sk = 3'b100;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.i_wb_req = 1'b1;
      bus.i_wb_rec = mkrec(64'(i), nc[i], sk[i], 32'd0);
      tick();
    end
    bus.i_wb_req  = 1'b0;
    bus.i_cmt_ack = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus.o_retire_cnt !== 64'd2 || bus.o_empty !== 1'b1) begin
      failures++;
      $display("FAIL nocmt_cnt got=%0d/%b exp=2/1",
               bus.o_retire_cnt, bus.o_empty);
    end
    bus.i_cmt_ack = 1'b0;
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.i_wb_req = 1'b1;
    bus.i_wb_rec = mkrec(64'h40, 1'b0, 1'b0, 32'd0);
    tick();
    bus.i_wb_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.o_hang !== 1'b0) begin
        failures++;
        $display("FAIL wd_early%0d got=%b exp=0", i, bus.o_hang);
      end
      tick();
    end
    checks++;
    if (bus.o_hang !== 1'b1) begin
      failures++;
      $display("FAIL wd_trip got=%b exp=1", bus.o_hang);
    end
    bus.i_cmt_ack = 1'b1;
    tick();
    bus.i_cmt_ack = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.o_hang !== 1'b1 || bus.o_empty !== 1'b1) begin
      failures++;
      $display("FAIL wd_sticky got=%b/%b exp=1/1",
               bus.o_hang, bus.o_empty);
    end
  endtask

  task automatic test_reset_mid_traffic();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.i_wb_req = 1'b1;
      bus.i_wb_rec = mkrec(64'(i), 1'b0, 1'b0, 32'd0);
      tick();
    end
    bus.i_wb_req  = 1'b0;
    bus.i_cmt_ack = 1'b1;
    tick();
    bus.i_cmt_ack = 1'b0;
    #1;
    checks++;
    if (bus.o_retire_cnt !== 64'd1 || bus.o_empty !== 1'b0) begin
      failures++;
      $display("FAIL mid_pre got=%0d/%b exp=1/0",
               bus.o_retire_cnt, bus.o_empty);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_empty !== 1'b1 || bus.o_cmt_req !== 1'b0 ||
        bus.o_retire_cnt !== 64'd0) begin
      failures++;
      $display("FAIL mid_async got=%b/%b/%0d exp=1/0/0",
               bus.o_empty, bus.o_cmt_req, bus.o_retire_cnt);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.o_empty !== 1'b1 || bus.o_cmt_rec !== '0) begin
      failures++;
      $display("FAIL mid_after got=%b/%0h exp=1/0",
               bus.o_empty, bus.o_cmt_rec);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_wb();
    test_arbitration();
    test_full_backpressure();
    test_nocmt();
    test_watchdog();
    test_reset_mid_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_210544_cmt_sched.md
Name: ysyx_210544_cmt_sched

Overview:
- Commit scheduler between the two commit sources and the commit stage.
- The two sources are the writeback stage (normal retire) and the trap unit (exception/interrupt commit records).
- Arbitrates between the sources and buffers records in a small FIFO.
- Presents one record at a time to the commit stage over a req/ack handshake. Also keeps a retire counter and a commit-hang watchdog.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
HANG_CYCLES, 4096, cycles with a non-empty FIFO and no commit before o_hang asserts

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
i_wb_req  in  1  writeback record valid
o_wb_ack  out  1  writeback record accepted this cycle
i_wb_rec  in  204  {rd[4:0], rd_wen, rd_wdata[63:0], pc[63:0], inst[31:0], nocmt, skipcmt, intrNo[31:0]}; intrNo=0 for writeback
i_trp_req  in  1  trap record valid
o_trp_ack  out  1  trap record accepted this cycle
i_trp_rec  in  204  same layout as i_wb_rec
o_cmt_req  out  1  head record valid toward commit stage
i_cmt_ack  in  1  commit stage accepts head
o_cmt_rec  out  204  head record
o_retire_cnt  out  64  count of committed records with nocmt=0
o_hang  out  1  watchdog tripped (sticky until reset)
o_full  out  1  FIFO full
o_empty  out  1  FIFO empty

Behaviour:
- Reset (rst=0, async) values:
  - FIFO empty; wr/rd pointers 0.
  - o_wb_ack=0, o_trp_ack=0, o_cmt_req=0, o_cmt_rec=0.
  - o_retire_cnt=0, o_hang=0, o_full=0, o_empty=1.
  - Watchdog counter 0.
  - Records in flight are discarded.
- Input arbitration, combinational within the cycle:
  - Trap has fixed priority: o_trp_ack = i_trp_req & !full_eff.
  - o_wb_ack = i_wb_req & !i_trp_req & !full_eff.
  - full_eff = o_full & !(o_cmt_req & i_cmt_ack); a pop in the same cycle frees a slot.
  - At most one push per cycle. A source holds req and record stable until ack.
- Push: on an ack, the selected record is written at wr_ptr and wr_ptr increments mod DEPTH.
- Occupancy:
  - Occupancy counter width clog2(DEPTH)+1.
  - o_full = (count==DEPTH); o_empty = (count==0).
- Output, zero-cycle FIFO read path:
  - o_cmt_req = !o_empty; o_cmt_rec = entry[rd_ptr].
  - A pushed record becomes visible the cycle after its push; no bypass. Minimum latency from push to o_cmt_req is 1 cycle.
- Pop: when o_cmt_req & i_cmt_ack, rd_ptr increments.
  - i_cmt_ack while o_cmt_req=0 is ignored.
  - o_cmt_rec holds steady while o_cmt_req=1 and i_cmt_ack=0.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal when full and when empty:
  - Empty: the pop does not occur, since req=0.
  - Full: the push is allowed via full_eff.
- Retire counter: increments by 1 on each pop whose head nocmt=0. skipcmt records count. Wraps at 2^64.
- Watchdog:
  - Counter resets to 0 on any pop and whenever the FIFO is empty.
  - Otherwise it increments each cycle and saturates at HANG_CYCLES.
  - o_hang sets when the counter reaches HANG_CYCLES and is cleared only by reset.
  - o_hang does not block traffic.
- Ordering: commit order equals acceptance order.

Test Plan:
- Reset mid-traffic: 3 records queued, assert rst=0 for 1 cycle -> o_empty=1, o_cmt_req=0, o_retire_cnt=0 immediately, with no clock edge needed.
- Single writeback: i_wb_req=1 with pc=0x80000000, i_cmt_ack=1 held -> o_wb_ack=1 at cycle 0; o_cmt_req=1 with pc=0x80000000 at cycle 1; o_retire_cnt=1 at cycle 2.
- Arbitration: i_wb_req and i_trp_req both high in the same cycle (trap intrNo=7) -> o_trp_ack=1, o_wb_ack=0. The trap record commits first, then the writeback record.
- Full plus backpressure: DEPTH=4, i_cmt_ack=0, 5 writeback pushes -> 4 acks, o_full=1, 5th o_wb_ack=0. Then i_cmt_ack=1 with the 5th request held -> push and pop in the same cycle, count stays 4.
- nocmt filtering: push 3 records with nocmt=1,0,0 and skipcmt=1 on the last, drain -> o_retire_cnt=2.
- Watchdog: HANG_CYCLES=16, 1 record queued, i_cmt_ack=0 -> o_hang=1 on the 16th cycle after the record becomes visible. o_hang stays 1 after the subsequent drain.
